// File: rtl/clk_dt_sched_pkg.sv
// clk_dt_sched_pkg: shared widths, table entry type and FSM state type for the clock phase sequencer
package clk_dt_sched_pkg;
  localparam int N_ENTRIES = 4;
  localparam int DT_WIDTH = 32;
  localparam int CNT_WIDTH = 16;
  localparam int IDX_W = $clog2(N_ENTRIES);
  typedef struct packed {
    logic [DT_WIDTH-1:0] lo;
    logic [DT_WIDTH-1:0] hi;
    logic [CNT_WIDTH-1:0] cycles;
  } sched_entry_t;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} sched_state_t;
endpackage

// File: rtl/clk_dt_sched_if.sv
// clk_dt_sched_if: config, control and generator-facing signals of the clock phase sequencer
// master drives cfg_*/start/stop/gen_rise and observes t_lo/t_hi/idx/busy/done/err; slave is the sequencer
interface clk_dt_sched_if;
  import clk_dt_sched_pkg::*;
  logic cfg_we_i;
  logic [IDX_W-1:0] cfg_addr_i;
  logic [DT_WIDTH-1:0] cfg_lo_i;
  logic [DT_WIDTH-1:0] cfg_hi_i;
  logic [CNT_WIDTH-1:0] cfg_cycles_i;
  logic start_i;
  logic stop_i;
  logic gen_rise_i;
  logic [DT_WIDTH-1:0] t_lo;
  logic [DT_WIDTH-1:0] t_hi;
  logic [IDX_W-1:0] idx_o;
  logic busy_o;
  logic done_o;
  logic err_o;
  modport master (
    output cfg_we_i, cfg_addr_i, cfg_lo_i, cfg_hi_i, cfg_cycles_i, start_i, stop_i, gen_rise_i,
    input t_lo, t_hi, idx_o, busy_o, done_o, err_o
  );
  modport slave (
    input cfg_we_i, cfg_addr_i, cfg_lo_i, cfg_hi_i, cfg_cycles_i, start_i, stop_i, gen_rise_i,
    output t_lo, t_hi, idx_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/clk_dt_sched_table.sv
// clk_dt_sched_table: phase table register file, one write port, reads at ra and ra+1, sync clear
// ports: clk_i, rst_ni (sync active-low clear), we/wa/wd write port, ra read index,
//        rd_a = entry[ra], rd_b_cycles = entry[ra+1].cycles (wraps at the table end)
module clk_dt_sched_table
  import clk_dt_sched_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic we,
  input  logic [IDX_W-1:0] wa,
  input  sched_entry_t wd,
  input  logic [IDX_W-1:0] ra,
  output sched_entry_t rd_a,
  output logic [CNT_WIDTH-1:0] rd_b_cycles
);
  sched_entry_t mem [N_ENTRIES];
  logic [IDX_W-1:0] rb;
  assign rb = IDX_W'(ra + 1'b1);
  always_ff @(posedge clk_i)
    if (!rst_ni) mem <= '{default: '0};
    else if (we) mem[wa] <= wd;
  assign rd_a = mem[ra];
  assign rd_b_cycles = mem[rb].cycles;
endmodule

// File: rtl/clk_dt_sched.sv
// clk_dt_sched: steps the generator's t_lo/t_hi through a table of phases, one phase per N generated periods
// ports: clk_i, rst_ni (sync active-low), bus (clk_dt_sched_if.slave): cfg_* table writes,
//        start_i/stop_i control, gen_rise_i generator edge pulse, t_lo/t_hi/idx_o/busy_o/done_o/err_o outputs
module clk_dt_sched
  import clk_dt_sched_pkg::*;
#(
  parameter bit LOOP = 1'b0
) (
  input logic clk_i,
  input logic rst_ni,
  clk_dt_sched_if.slave bus
);
  sched_state_t state;
  logic [IDX_W-1:0] idx;
  logic [CNT_WIDTH-1:0] cnt;
  sched_entry_t cur;
  logic [CNT_WIDTH-1:0] nxt_cycles;
  logic idle, we_ok, e0_zero, last;
  assign idle = state == IDLE || state == DONE;
  assign we_ok = bus.cfg_we_i && idle;
  // while idle the read port points at entry 0 so start can validate it
  clk_dt_sched_table u_table (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .we(we_ok),
    .wa(bus.cfg_addr_i),
    .wd('{lo: bus.cfg_lo_i, hi: bus.cfg_hi_i, cycles: bus.cfg_cycles_i}),
    .ra(idle ? '0 : idx),
    .rd_a(cur),
    .rd_b_cycles(nxt_cycles)
  );
  // a same-cycle write to entry 0 is seen by the start check
  assign e0_zero = (we_ok && bus.cfg_addr_i == '0) ? bus.cfg_cycles_i == '0 : cur.cycles == '0;
  assign last = idx == IDX_W'(N_ENTRIES - 1) || nxt_cycles == '0;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      bus.t_lo <= '0;
      bus.t_hi <= '0;
      bus.busy_o <= 1'b0;
      bus.done_o <= 1'b0;
      bus.err_o <= 1'b0;
    end else begin
      bus.done_o <= 1'b0;
      if (bus.cfg_we_i && !idle) bus.err_o <= 1'b1;
      if (bus.stop_i) begin
        state <= IDLE;
        bus.busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            state <= IDLE;
            if (bus.start_i) begin
              if (e0_zero) bus.err_o <= 1'b1;
              else begin
                state <= LOAD;
                idx <= '0;
                bus.busy_o <= 1'b1;
                bus.err_o <= 1'b0;
              end
            end
          end
          LOAD: begin
            bus.t_lo <= cur.lo;
            bus.t_hi <= cur.hi;
            cnt <= cur.cycles;
            state <= RUN;
          end
          RUN: begin
            // a phase ends only on a generated rising edge, so no half-period is split
            if (bus.gen_rise_i && cnt == CNT_WIDTH'(1)) begin
              if (!last || LOOP) begin
                idx <= last ? '0 : IDX_W'(idx + 1'b1);
                state <= LOAD;
              end else begin
                state <= DONE;
                bus.busy_o <= 1'b0;
                bus.done_o <= 1'b1;
              end
            end else if (bus.gen_rise_i) cnt <= cnt - 1'b1;
          end
        endcase
      end
    end
  end
  assign bus.idx_o = idx;
endmodule

// File: tb/tb_clk_dt_sched.sv
// tb_clk_dt_sched: drives a LOOP=0 and a LOOP=1 sequencer with identical stimulus and checks both against a phase-schedule model
module tb_clk_dt_sched;
  import clk_dt_sched_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic we = 1'b0, start = 1'b0, stop = 1'b0, rise = 1'b0;
  logic [IDX_W-1:0] addr = '0;
  logic [DT_WIDTH-1:0] lo = '0, hi = '0;
  logic [CNT_WIDTH-1:0] cyc = '0;
  clk_dt_sched_if b0 ();
  clk_dt_sched_if b1 ();
  assign b0.cfg_we_i = we;
  assign b0.cfg_addr_i = addr;
  assign b0.cfg_lo_i = lo;
  assign b0.cfg_hi_i = hi;
  assign b0.cfg_cycles_i = cyc;
  assign b0.start_i = start;
  assign b0.stop_i = stop;
  assign b0.gen_rise_i = rise;
  assign b1.cfg_we_i = we;
  assign b1.cfg_addr_i = addr;
  assign b1.cfg_lo_i = lo;
  assign b1.cfg_hi_i = hi;
  assign b1.cfg_cycles_i = cyc;
  assign b1.start_i = start;
  assign b1.stop_i = stop;
  assign b1.gen_rise_i = rise;
  clk_dt_sched #(.LOOP(1'b0)) u0 (.clk_i(clk), .rst_ni(rst_n), .bus(b0));
  clk_dt_sched #(.LOOP(1'b1)) u1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1));

  int errors = 0, checks = 0;
  int edges = 0, last_rise = -10;
  int k = 0;
  sched_entry_t tbl [N_ENTRIES];
  always @(posedge clk) edges++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int used();
    int n = 0;
    while (n < N_ENTRIES && tbl[n].cycles != '0) n++;
    return n;
  endfunction

  function automatic int total();
    int s = 0;
    for (int i = 0; i < used(); i++) s += int'(tbl[i].cycles);
    return s;
  endfunction

  // entry active after r counted rises, from cumulative phase lengths
  function automatic int pos(input int r, input bit loop, output bit fin);
    int s = total();
    int j = 0;
    fin = !loop && r >= s;
    if (fin) return used() - 1;
    r = r % s;
    while (r >= int'(tbl[j].cycles)) begin
      r -= int'(tbl[j].cycles);
      j++;
    end
    return j;
  endfunction

  task automatic check_out(input string tag);
    bit f0, f1;
    int j0, j1;
    j0 = pos(k, 1'b0, f0);
    j1 = pos(k, 1'b1, f1);
    chk({tag, ".idx0"}, b0.idx_o, j0);
    chk({tag, ".lo0"}, b0.t_lo, tbl[j0].lo);
    chk({tag, ".hi0"}, b0.t_hi, tbl[j0].hi);
    chk({tag, ".busy0"}, b0.busy_o, !f0);
    chk({tag, ".idx1"}, b1.idx_o, j1);
    chk({tag, ".lo1"}, b1.t_lo, tbl[j1].lo);
    chk({tag, ".hi1"}, b1.t_hi, tbl[j1].hi);
    chk({tag, ".busy1"}, b1.busy_o, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".lo0"}, b0.t_lo, 0);
    chk({tag, ".hi0"}, b0.t_hi, 0);
    chk({tag, ".st0"}, {b0.idx_o, b0.busy_o, b0.done_o, b0.err_o}, 0);
    chk({tag, ".lo1"}, b1.t_lo, 0);
    chk({tag, ".hi1"}, b1.t_hi, 0);
    chk({tag, ".st1"}, {b1.idx_o, b1.busy_o, b1.done_o, b1.err_o}, 0);
  endtask

  task automatic wr(input int a, input logic [DT_WIDTH-1:0] l, input logic [DT_WIDTH-1:0] h,
                    input int c, input bit ok);
    we = 1'b1;
    addr = IDX_W'(a);
    lo = l;
    hi = h;
    cyc = CNT_WIDTH'(c);
    tick();
    we = 1'b0;
    if (ok) tbl[a] = '{lo: l, hi: h, cycles: CNT_WIDTH'(c)};
  endtask

  task automatic go(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    chk({tag, ".busy0"}, b0.busy_o, 1'b1);
    chk({tag, ".busy1"}, b1.busy_o, 1'b1);
    chk({tag, ".err"}, {b0.err_o, b1.err_o}, 2'b00);
    tick();
    check_out(tag);
  endtask

  task automatic pulse(input string tag);
    chk({tag, ".gap"}, (edges + 1 - last_rise) >= 2, 1'b1);
    last_rise = edges + 1;
    rise = 1'b1;
    tick();
    rise = 1'b0;
    k++;
    chk({tag, ".done0"}, b0.done_o, k == total());
    chk({tag, ".done1"}, b1.done_o, 1'b0);
    tick();
    check_out(tag);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("halt.busy", {b0.busy_o, b1.busy_o}, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < N_ENTRIES; i++) tbl[i] = '0;
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();
    wr(0, 123, 234, 3, 1);
    wr(1, 200, 100, 2, 1);
    wr(2, 0, 0, 0, 1);
    go("seq");
    chk("seq.lo_start", b0.t_lo, 123);
    chk("seq.hi_start", b0.t_hi, 234);
    for (int i = 0; i < 12; i++) begin
      pulse("seq");
      if (i == 2) chk("seq.lo_r3", {b0.t_lo, b0.t_hi}, {32'd200, 32'd100});
      if (i == 4) chk("seq.hold_r5", {b0.busy_o, b0.t_lo, b0.t_hi}, {1'b0, 32'd200, 32'd100});
      if (i == 7) chk("seq.loop_r8", b1.idx_o, 1);
    end
    halt();
    go("stp");
    pulse("stp");
    pulse("stp");
    stop = 1'b1;
    rise = 1'b1;
    tick();
    stop = 1'b0;
    rise = 1'b0;
    chk("stp.done", {b0.done_o, b1.done_o}, 2'b00);
    chk("stp.busy", {b0.busy_o, b1.busy_o}, 2'b00);
    tick();
    tick();
    chk("stp.hold0", {b0.idx_o, b0.t_lo, b0.t_hi}, {2'd0, 32'd123, 32'd234});
    chk("stp.hold1", {b1.idx_o, b1.t_lo, b1.t_hi}, {2'd0, 32'd123, 32'd234});
    go("bw");
    wr(1, 7, 7, 9, 0);
    chk("bw.err", {b0.err_o, b1.err_o}, 2'b11);
    for (int i = 0; i < 3; i++) pulse("bw");
    chk("bw.kept", b0.t_lo, 200);
    halt();
    chk("bw.sticky", {b0.err_o, b1.err_o}, 2'b11);
    go("bw2");
    halt();
    we = 1'b1;
    addr = '0;
    lo = 5;
    hi = 6;
    cyc = '0;
    start = 1'b1;
    tick();
    we = 1'b0;
    start = 1'b0;
    tbl[0] = '{lo: 5, hi: 6, cycles: '0};
    chk("e0z.err", {b0.err_o, b1.err_o}, 2'b11);
    chk("e0z.busy", {b0.busy_o, b1.busy_o}, 2'b00);
    tick();
    chk("e0z.idle", {b0.busy_o, b1.busy_o, b0.done_o}, 3'b000);
    for (int i = 0; i < N_ENTRIES; i++) wr(i, $urandom, $urandom, $urandom_range(1, 3), 1);
    go("all4");
    for (int i = 0; i < total() + 2; i++) pulse("all4");
    chk("all4.idx", b0.idx_o, N_ENTRIES - 1);
    halt();
    for (int t = 0; t < 4; t++) begin
      int n = $urandom_range(1, N_ENTRIES);
      for (int i = 0; i < N_ENTRIES; i++) wr(i, $urandom, $urandom, i < n ? $urandom_range(1, 4) : 0, 1);
      go("rnd");
      for (int i = 0; i < total() * 2 + $urandom_range(0, 3); i++) pulse("rnd");
      halt();
    end
    go("rst");
    pulse("rst");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N_ENTRIES; i++) tbl[i] = '0;
    check_zero("rst");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst.tbl_err", {b0.err_o, b1.err_o, b0.busy_o, b1.busy_o}, 4'b1100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clk_dt_sched.md
Name: clk_dt_sched

Overview:
- Sequences the low/high half-period programming (t_lo/t_hi, in DT_SCALE units) of a single emulated clock generator through a small table of phases.
- Each phase holds a (t_lo, t_hi, cycle count) entry and applies for that many generated clock periods, then the next entry is loaded.
- Sits between the sim-control/config logic and the clock generator's t_lo/t_hi inputs. Used for frequency-sweep and duty-cycle-step emulation tests.

Parameters:
- N_ENTRIES, 4, number of table entries (power of two, >=2)
- DT_WIDTH, 32, width of t_lo/t_hi values
- CNT_WIDTH, 16, width of per-entry period count
- LOOP, 0, 1 = wrap from the last used entry back to entry 0 instead of finishing

Ports:
- clk_i  in  1  emulator clock; all logic on rising edge
- rst_ni  in  1  synchronous active-low reset
- cfg_we_i  in  1  table write strobe
- cfg_addr_i  in  $clog2(N_ENTRIES)  table write index
- cfg_lo_i  in  DT_WIDTH  low duration for the entry
- cfg_hi_i  in  DT_WIDTH  high duration for the entry
- cfg_cycles_i  in  CNT_WIDTH  generated periods for the entry; 0 marks end of table
- start_i  in  1  one-cycle pulse, begin the sequence at entry 0
- stop_i  in  1  one-cycle pulse, abort to IDLE
- gen_rise_i  in  1  one-cycle pulse per rising edge of the generated clock, already synchronous to clk_i
- t_lo  out  DT_WIDTH  low-duration value driven to the generator
- t_hi  out  DT_WIDTH  high-duration value driven to the generator
- idx_o  out  $clog2(N_ENTRIES)  active entry index
- busy_o  out  1  sequence running
- done_o  out  1  one-cycle pulse when the sequence completes
- err_o  out  1  sticky; cfg write attempted while busy, or start with entry 0 count==0

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - table entries are cleared to 0; t_lo = t_hi = 0 and all other outputs are 0; state is IDLE.
- Table writes:
  - Accepted only in IDLE/DONE; the entry is written on the cycle cfg_we_i=1.
  - A write in LOAD/RUN is dropped and sets err_o.
  - err_o clears only on reset or on an accepted start_i.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: start_i -> if entry0.cycles==0, set err_o and stay IDLE; else go to LOAD with idx=0.
  - LOAD (1 cycle): t_lo/t_hi <= entry[idx].lo/hi; cnt <= entry[idx].cycles; busy_o=1; then go to RUN.
    - New t_lo/t_hi are visible the cycle after LOAD, so latency start_i -> t_lo valid = 2 clk_i cycles.
  - RUN: each gen_rise_i decrements cnt. When gen_rise_i arrives with cnt==1, the next index is evaluated:
    - next = idx+1. If next==N_ENTRIES or entry[next].cycles==0: with LOOP=1 go to LOAD idx=0; with LOOP=0 go to DONE.
    - Otherwise go to LOAD idx=next.
    - Parameter changes therefore take effect only following a generated rising edge, so a half-period is never split.
  - DONE: done_o=1 for exactly one cycle, busy_o=0, t_lo/t_hi hold their last values, then go to IDLE.
    - start_i in DONE is treated as in IDLE on the following cycle.
- Simultaneous events:
  - stop_i has priority over start_i and gen_rise_i: from any state go to IDLE next cycle, busy_o=0, no done_o, t_lo/t_hi hold.
  - start_i while in LOAD/RUN is ignored; it does not set err_o.
  - cfg_we_i together with start_i in IDLE: the write commits first and the start reads the new table (write-through on same cycle for entry 0).
- gen_rise_i in LOAD is not counted. Generator edges are assumed no closer than 2 clk_i cycles; the bench checks this.
- Counter is CNT_WIDTH unsigned with no wrap, because it never decrements below 1 in RUN.
- Reset mid-sequence returns to the IDLE reset values on the next edge and clears the table.

Decomposition:
- Package clk_dt_sched_pkg:
  - typedef sched_entry_t {lo, hi, cycles}
  - enum sched_state_t {IDLE, LOAD, RUN, DONE}
  - localparam IDX_W
- Sub-module sched_table: N_ENTRIES-deep register file with 1 write port, 2 combinational read ports (idx and idx+1), and synchronous clear on reset.

Test Plan:
- Program entry0 = (123, 234, 3) and entry1 = (200, 100, 2), entry2 cycles=0, LOOP=0, start:
  - t_lo=123/t_hi=234 two cycles after start;
  - switch to 200/100 after the 3rd gen_rise_i;
  - done_o pulse after the 2nd further gen_rise_i; busy_o=0; outputs hold 200/100.
- LOOP=1 with the same table and 12 gen_rise_i pulses: idx_o sequence 0,1,0,1,… with switch points at rises 3, 5, 8, 10.
- stop_i in RUN asserted on the same cycle as gen_rise_i with cnt==1 -> IDLE, no LOAD, no done_o, t_lo/t_hi unchanged.
- cfg_we_i during RUN -> table unchanged (read back on next run), err_o=1. Next accepted start_i clears err_o.
- start_i with entry0.cycles=0 -> stays IDLE, err_o=1, busy_o=0. All 4 entries nonzero, LOOP=0 -> done_o after entry3 completes.
- Assert rst_ni=0 for one cycle mid-RUN -> next cycle all outputs 0, state IDLE, table entries read 0.
